// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundles the decode-side inputs (ds_i_*) and EX-side outputs (ds_o_*) of
//   the ID/EX pipeline register.
//   slave  : used by id_ex_stage (ds_i_* in, ds_o_* out)
//   master : used by whatever drives the decode slot (ds_i_* out, ds_o_* in)
//
//   Flow control: there is no valid/ready pair. ds_i_valid marks a real
//   instruction in the decode slot. ds_o_stall=1 means the decode slot is not
//   consumed this edge and IF/ID must present the same instruction again.
//   ds_i_hold=1 freezes this register and the bubble counter. ds_i_change_pc=1
//   discards whatever is in decode and loads a bubble.
interface id_ex_stage_if #(
    parameter int DWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 16,
    parameter int AWIDTH    = 5,
    parameter int CWIDTH    = 16
) ();
    logic                 ds_i_valid;
    logic [AWIDTH-1:0]    ds_i_rs_addr;
    logic [AWIDTH-1:0]    ds_i_rt_addr;
    logic [AWIDTH-1:0]    ds_i_rd_addr;
    logic [DWIDTH-1:0]    ds_i_data_rs;
    logic [DWIDTH-1:0]    ds_i_data_rt;
    logic [IMM_WIDTH-1:0] ds_i_imm;
    logic [4:0]           ds_i_funct;
    logic                 ds_i_alu_src;
    logic [PC_WIDTH-1:0]  ds_i_pc;
    logic                 ds_i_reg_write;
    logic                 ds_i_mem_read;
    logic                 ds_i_mem_write;
    logic                 ds_i_hold;
    logic                 ds_i_change_pc;
    logic                 ds_i_exmem_reg_write;
    logic [AWIDTH-1:0]    ds_i_exmem_rd;
    logic [DWIDTH-1:0]    ds_i_exmem_value;
    logic                 ds_i_memwb_reg_write;
    logic [AWIDTH-1:0]    ds_i_memwb_rd;
    logic [DWIDTH-1:0]    ds_i_memwb_value;

    logic                 ds_o_valid;
    logic [DWIDTH-1:0]    ds_o_data_rs;
    logic [DWIDTH-1:0]    ds_o_data_rt;
    logic [IMM_WIDTH-1:0] ds_o_imm;
    logic [4:0]           ds_o_funct;
    logic                 ds_o_alu_src;
    logic [PC_WIDTH-1:0]  ds_o_pc;
    logic [AWIDTH-1:0]    ds_o_rd;
    logic                 ds_o_reg_write;
    logic                 ds_o_mem_read;
    logic                 ds_o_mem_write;
    logic                 ds_o_stall;
    logic [CWIDTH-1:0]    ds_o_bubble_cnt;

    modport slave (
        input  ds_i_valid, ds_i_rs_addr, ds_i_rt_addr, ds_i_rd_addr,
               ds_i_data_rs, ds_i_data_rt, ds_i_imm, ds_i_funct, ds_i_alu_src,
               ds_i_pc, ds_i_reg_write, ds_i_mem_read, ds_i_mem_write,
               ds_i_hold, ds_i_change_pc,
               ds_i_exmem_reg_write, ds_i_exmem_rd, ds_i_exmem_value,
               ds_i_memwb_reg_write, ds_i_memwb_rd, ds_i_memwb_value,
        output ds_o_valid, ds_o_data_rs, ds_o_data_rt, ds_o_imm, ds_o_funct,
               ds_o_alu_src, ds_o_pc, ds_o_rd, ds_o_reg_write, ds_o_mem_read,
               ds_o_mem_write, ds_o_stall, ds_o_bubble_cnt
    );

    modport master (
        output ds_i_valid, ds_i_rs_addr, ds_i_rt_addr, ds_i_rd_addr,
               ds_i_data_rs, ds_i_data_rt, ds_i_imm, ds_i_funct, ds_i_alu_src,
               ds_i_pc, ds_i_reg_write, ds_i_mem_read, ds_i_mem_write,
               ds_i_hold, ds_i_change_pc,
               ds_i_exmem_reg_write, ds_i_exmem_rd, ds_i_exmem_value,
               ds_i_memwb_reg_write, ds_i_memwb_rd, ds_i_memwb_value,
        input  ds_o_valid, ds_o_data_rs, ds_o_data_rt, ds_o_imm, ds_o_funct,
               ds_o_alu_src, ds_o_pc, ds_o_rd, ds_o_reg_write, ds_o_mem_read,
               ds_o_mem_write, ds_o_stall, ds_o_bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection, EX/MEM and
//   MEM/WB operand forwarding and a saturating count of inserted bubbles.
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - synchronous active-high reset (loads a bubble, clears count)
//     ds   - id_ex_stage_if.slave: decode inputs ds_i_*, EX outputs ds_o_*
//   Each edge takes exactly one action: rst > flush > hold > stall > load.
module id_ex_stage #(
    parameter int DWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 16,
    parameter int AWIDTH    = 5,
    parameter int CWIDTH    = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave ds
);

    typedef struct packed {
        logic                 valid;
        logic [AWIDTH-1:0]    rs_addr;
        logic [AWIDTH-1:0]    rt_addr;
        logic [AWIDTH-1:0]    rd;
        logic [DWIDTH-1:0]    data_rs;
        logic [DWIDTH-1:0]    data_rt;
        logic [IMM_WIDTH-1:0] imm;
        logic [4:0]           funct;
        logic                 alu_src;
        logic [PC_WIDTH-1:0]  pc;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } ex_t;

    // Funct 31 parks the ALU; everything else in a bubble is zero.
    function automatic ex_t bubble();
        ex_t b;
        b       = '0;
        b.funct = 5'd31;
        return b;
    endfunction

    ex_t               ex_q, ex_d;
    logic [CWIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
    logic              load_use;
    logic              stall;
    logic [DWIDTH-1:0] fwd_rs;
    logic [DWIDTH-1:0] fwd_rt;

    // Load-use hazard: the load in EX produces its value too late for the
    // instruction in decode. rt only counts when it is really read as a
    // register (ALU operand, or store data).
    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                   ds.ds_i_valid &&
                   ((ex_q.rd == ds.ds_i_rs_addr) ||
                    ((ex_q.rd == ds.ds_i_rt_addr) &&
                     (!ds.ds_i_alu_src || ds.ds_i_mem_write)));
        // A flush or hold owns the edge, so no stall is reported then.
        stall = load_use && !ds.ds_i_change_pc && !ds.ds_i_hold;
    end

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ds.ds_i_change_pc || (!ds.ds_i_hold && stall)) begin
            ex_d         = bubble();
            // Saturate rather than wrap.
            bubble_cnt_d = (bubble_cnt_q == '1) ? bubble_cnt_q
                                                : bubble_cnt_q + CWIDTH'(1);
        end else if (!ds.ds_i_hold) begin
            ex_d.valid     = ds.ds_i_valid;
            ex_d.rs_addr   = ds.ds_i_rs_addr;
            ex_d.rt_addr   = ds.ds_i_rt_addr;
            ex_d.rd        = ds.ds_i_rd_addr;
            ex_d.data_rs   = ds.ds_i_data_rs;
            ex_d.data_rt   = ds.ds_i_data_rt;
            ex_d.imm       = ds.ds_i_imm;
            ex_d.funct     = ds.ds_i_funct;
            ex_d.alu_src   = ds.ds_i_alu_src;
            ex_d.pc        = ds.ds_i_pc;
            ex_d.reg_write = ds.ds_i_reg_write;
            ex_d.mem_read  = ds.ds_i_mem_read;
            ex_d.mem_write = ds.ds_i_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= bubble();
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Forwarding: the younger EX/MEM result beats MEM/WB. Requiring rd!=0
    // keeps register 0 on its registered value.
    always_comb begin
        fwd_rs = ex_q.data_rs;
        if (ds.ds_i_exmem_reg_write && (ds.ds_i_exmem_rd != '0) &&
            (ds.ds_i_exmem_rd == ex_q.rs_addr)) begin
            fwd_rs = ds.ds_i_exmem_value;
        end else if (ds.ds_i_memwb_reg_write && (ds.ds_i_memwb_rd != '0) &&
                     (ds.ds_i_memwb_rd == ex_q.rs_addr)) begin
            fwd_rs = ds.ds_i_memwb_value;
        end

        fwd_rt = ex_q.data_rt;
        if (ds.ds_i_exmem_reg_write && (ds.ds_i_exmem_rd != '0) &&
            (ds.ds_i_exmem_rd == ex_q.rt_addr)) begin
            fwd_rt = ds.ds_i_exmem_value;
        end else if (ds.ds_i_memwb_reg_write && (ds.ds_i_memwb_rd != '0) &&
                     (ds.ds_i_memwb_rd == ex_q.rt_addr)) begin
            fwd_rt = ds.ds_i_memwb_value;
        end
    end

    assign ds.ds_o_valid      = ex_q.valid;
    assign ds.ds_o_data_rs    = fwd_rs;
    assign ds.ds_o_data_rt    = fwd_rt;
    assign ds.ds_o_imm        = ex_q.imm;
    assign ds.ds_o_funct      = ex_q.funct;
    assign ds.ds_o_alu_src    = ex_q.alu_src;
    assign ds.ds_o_pc         = ex_q.pc;
    assign ds.ds_o_rd         = ex_q.rd;
    assign ds.ds_o_reg_write  = ex_q.reg_write;
    assign ds.ds_o_mem_read   = ex_q.mem_read;
    assign ds.ds_o_mem_write  = ex_q.mem_write;
    assign ds.ds_o_stall      = stall;
    assign ds.ds_o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Drives id_ex_stage (CWIDTH=2 so counter saturation is reachable) through
//   directed scenarios and a randomized run, checking every output each cycle
//   against a behavioural model of the ID/EX register.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int PW = 32;
    localparam int IW = 16;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    logic check_en;
    int   tests_run;
    int   tests_failed;

    id_ex_stage_if #(.DWIDTH(DW), .PC_WIDTH(PW), .IMM_WIDTH(IW),
                     .AWIDTH(AW), .CWIDTH(CW)) bus ();

    id_ex_stage #(.DWIDTH(DW), .PC_WIDTH(PW), .IMM_WIDTH(IW),
                  .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .ds  (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic          m_valid;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    logic [DW-1:0] m_drs, m_drt;
    logic [IW-1:0] m_imm;
    logic [4:0]    m_funct;
    logic          m_alu_src;
    logic [PW-1:0] m_pc;
    logic          m_rw, m_mr, m_mw;
    int            m_cnt;

    task automatic m_bubble();
        m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_drs = '0; m_drt = '0; m_imm = '0; m_funct = 5'd31;
        m_alu_src = 1'b0; m_pc = '0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    endtask

    // A load in EX whose target is read by the real instruction in decode.
    function automatic logic exp_stall();
        logic uses_rt;
        logic hazard;
        uses_rt = !bus.ds_i_alu_src || bus.ds_i_mem_write;
        hazard  = m_valid && m_mr && (m_rd != 0) && bus.ds_i_valid &&
                  ((m_rd == bus.ds_i_rs_addr) ||
                   (uses_rt && (m_rd == bus.ds_i_rt_addr)));
        return hazard && !bus.ds_i_change_pc && !bus.ds_i_hold;
    endfunction

    // Apply sources oldest first so the youngest matching one remains.
    function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] a,
                                              input logic [DW-1:0] regval);
        logic [DW-1:0] r;
        r = regval;
        if (a != 0) begin
            if (bus.ds_i_memwb_reg_write && bus.ds_i_memwb_rd == a) r = bus.ds_i_memwb_value;
            if (bus.ds_i_exmem_reg_write && bus.ds_i_exmem_rd == a) r = bus.ds_i_exmem_value;
        end
        return r;
    endfunction

    always @(posedge clk) begin : model_update
        logic s;
        s = exp_stall();
        if (rst) begin
            m_bubble();
            m_cnt = 0;
        end else if (bus.ds_i_change_pc || (!bus.ds_i_hold && s)) begin
            m_bubble();
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else if (!bus.ds_i_hold) begin
            m_valid = bus.ds_i_valid; m_rs = bus.ds_i_rs_addr; m_rt = bus.ds_i_rt_addr;
            m_rd = bus.ds_i_rd_addr; m_drs = bus.ds_i_data_rs; m_drt = bus.ds_i_data_rt;
            m_imm = bus.ds_i_imm; m_funct = bus.ds_i_funct; m_alu_src = bus.ds_i_alu_src;
            m_pc = bus.ds_i_pc; m_rw = bus.ds_i_reg_write; m_mr = bus.ds_i_mem_read;
            m_mw = bus.ds_i_mem_write;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            chk("valid",     64'(bus.ds_o_valid),      64'(m_valid));
            chk("data_rs",   64'(bus.ds_o_data_rs),    64'(exp_fwd(m_rs, m_drs)));
            chk("data_rt",   64'(bus.ds_o_data_rt),    64'(exp_fwd(m_rt, m_drt)));
            chk("imm",       64'(bus.ds_o_imm),        64'(m_imm));
            chk("funct",     64'(bus.ds_o_funct),      64'(m_funct));
            chk("alu_src",   64'(bus.ds_o_alu_src),    64'(m_alu_src));
            chk("pc",        64'(bus.ds_o_pc),         64'(m_pc));
            chk("rd",        64'(bus.ds_o_rd),         64'(m_rd));
            chk("reg_write", 64'(bus.ds_o_reg_write),  64'(m_rw));
            chk("mem_read",  64'(bus.ds_o_mem_read),   64'(m_mr));
            chk("mem_write", 64'(bus.ds_o_mem_write),  64'(m_mw));
            chk("stall",     64'(bus.ds_o_stall),      64'(exp_stall()));
            chk("bubble_cnt", 64'(bus.ds_o_bubble_cnt), 64'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.ds_i_valid = 1'b0; bus.ds_i_rs_addr = '0; bus.ds_i_rt_addr = '0;
        bus.ds_i_rd_addr = '0; bus.ds_i_data_rs = '0; bus.ds_i_data_rt = '0;
        bus.ds_i_imm = '0; bus.ds_i_funct = '0; bus.ds_i_alu_src = 1'b0;
        bus.ds_i_pc = '0; bus.ds_i_reg_write = 1'b0; bus.ds_i_mem_read = 1'b0;
        bus.ds_i_mem_write = 1'b0; bus.ds_i_hold = 1'b0; bus.ds_i_change_pc = 1'b0;
        bus.ds_i_exmem_reg_write = 1'b0; bus.ds_i_exmem_rd = '0; bus.ds_i_exmem_value = '0;
        bus.ds_i_memwb_reg_write = 1'b0; bus.ds_i_memwb_rd = '0; bus.ds_i_memwb_value = '0;
    endtask

    task automatic drive_instr(input logic [AW-1:0] rs, input logic [DW-1:0] drs,
                               input logic [AW-1:0] rt, input logic [DW-1:0] drt,
                               input logic [AW-1:0] rd, input logic [4:0] funct,
                               input logic alu_src, input logic mem_read,
                               input logic [PW-1:0] pc);
        bus.ds_i_valid = 1'b1; bus.ds_i_rs_addr = rs; bus.ds_i_data_rs = drs;
        bus.ds_i_rt_addr = rt; bus.ds_i_data_rt = drt; bus.ds_i_rd_addr = rd;
        bus.ds_i_funct = funct; bus.ds_i_alu_src = alu_src; bus.ds_i_mem_read = mem_read;
        bus.ds_i_mem_write = 1'b0; bus.ds_i_reg_write = 1'b1; bus.ds_i_imm = 16'h0004;
        bus.ds_i_pc = pc;
    endtask

    task automatic drive_random();
        bus.ds_i_valid = ($urandom_range(0, 3) != 0);
        bus.ds_i_rs_addr = AW'($urandom_range(0, 7));
        bus.ds_i_rt_addr = AW'($urandom_range(0, 7));
        bus.ds_i_rd_addr = AW'($urandom_range(0, 7));
        bus.ds_i_data_rs = $urandom; bus.ds_i_data_rt = $urandom;
        bus.ds_i_imm = IW'($urandom); bus.ds_i_funct = 5'($urandom_range(0, 16));
        bus.ds_i_alu_src = 1'($urandom_range(0, 1)); bus.ds_i_pc = $urandom;
        bus.ds_i_reg_write = 1'($urandom_range(0, 1));
        bus.ds_i_mem_read = ($urandom_range(0, 2) == 0);
        bus.ds_i_mem_write = ($urandom_range(0, 4) == 0);
        bus.ds_i_hold = ($urandom_range(0, 7) == 0);
        bus.ds_i_change_pc = ($urandom_range(0, 9) == 0);
        bus.ds_i_exmem_reg_write = 1'($urandom_range(0, 1));
        bus.ds_i_exmem_rd = AW'($urandom_range(0, 7)); bus.ds_i_exmem_value = $urandom;
        bus.ds_i_memwb_reg_write = 1'($urandom_range(0, 1));
        bus.ds_i_memwb_rd = AW'($urandom_range(0, 7)); bus.ds_i_memwb_value = $urandom;
        rst = ($urandom_range(0, 199) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 3, 3};
        tests_run = 0;
        tests_failed = 0;
        check_en = 1'b0;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_en = 1'b1;
        settle();
        chk("reset valid", 64'(bus.ds_o_valid), 64'd0);
        chk("reset funct", 64'(bus.ds_o_funct), 64'd31);
        chk("reset cnt",   64'(bus.ds_o_bubble_cnt), 64'd0);
        rst = 1'b0;
        settle();
        chk("stall after reset", 64'(bus.ds_o_stall), 64'd0);

        // Passthrough
        drive_instr(5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 5'd0, 1'b0, 1'b0, 32'h100);
        tick(); settle();
        chk("pass valid",   64'(bus.ds_o_valid),   64'd1);
        chk("pass funct",   64'(bus.ds_o_funct),   64'd0);
        chk("pass data_rs", 64'(bus.ds_o_data_rs), 64'd5);
        chk("pass data_rt", 64'(bus.ds_o_data_rt), 64'd7);
        chk("pass pc",      64'(bus.ds_o_pc),      64'h100);

        // Forward priority, EX frozen by hold
        bus.ds_i_hold = 1'b1;
        bus.ds_i_exmem_reg_write = 1'b1; bus.ds_i_exmem_rd = 5'd3; bus.ds_i_exmem_value = 32'h11;
        bus.ds_i_memwb_reg_write = 1'b1; bus.ds_i_memwb_rd = 5'd3; bus.ds_i_memwb_value = 32'h22;
        settle();
        chk("fwd exmem wins", 64'(bus.ds_o_data_rs), 64'h11);
        bus.ds_i_exmem_reg_write = 1'b0;
        settle();
        chk("fwd memwb", 64'(bus.ds_o_data_rs), 64'h22);
        tick(); settle();
        chk("hold keeps valid", 64'(bus.ds_o_valid), 64'd1);
        chk("hold keeps pc",    64'(bus.ds_o_pc),    64'h100);
        chk("hold keeps cnt",   64'(bus.ds_o_bubble_cnt), 64'd0);
        idle_inputs();

        // Load-use stall
        drive_instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd8, 5'd0, 1'b1, 1'b1, 32'h104);
        tick();
        drive_instr(5'd8, 32'd0, 5'd2, 32'd2, 5'd10, 5'd1, 1'b1, 1'b0, 32'h108);
        settle();
        chk("load-use stall", 64'(bus.ds_o_stall), 64'd1);
        tick(); settle();
        chk("stall bubble valid", 64'(bus.ds_o_valid), 64'd0);
        chk("stall bubble funct", 64'(bus.ds_o_funct), 64'd31);
        chk("stall cnt",          64'(bus.ds_o_bubble_cnt), 64'd1);
        chk("stall released",     64'(bus.ds_o_stall), 64'd0);
        tick(); settle();
        chk("after stall valid", 64'(bus.ds_o_valid), 64'd1);
        chk("after stall funct", 64'(bus.ds_o_funct), 64'd1);
        chk("after stall rd",    64'(bus.ds_o_rd),    64'd10);

        // Flush beats stall and hold
        drive_instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd8, 5'd0, 1'b1, 1'b1, 32'h10c);
        tick();
        drive_instr(5'd8, 32'd0, 5'd2, 32'd2, 5'd10, 5'd1, 1'b1, 1'b0, 32'h110);
        bus.ds_i_change_pc = 1'b1;
        bus.ds_i_hold = 1'b1;
        settle();
        chk("flush stall out", 64'(bus.ds_o_stall), 64'd0);
        tick(); settle();
        chk("flush valid", 64'(bus.ds_o_valid), 64'd0);
        chk("flush cnt",   64'(bus.ds_o_bubble_cnt), 64'd2);
        idle_inputs();

        // Register 0 never forwarded
        drive_instr(5'd0, 32'd0, 5'd5, 32'd3, 5'd6, 5'd2, 1'b0, 1'b0, 32'h114);
        tick();
        idle_inputs();
        bus.ds_i_exmem_reg_write = 1'b1; bus.ds_i_exmem_rd = 5'd0; bus.ds_i_exmem_value = 32'hFF;
        settle();
        chk("r0 not forwarded", 64'(bus.ds_o_data_rs), 64'd0);
        idle_inputs();

        // Saturation, then reset during hold
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("sat start cnt", 64'(bus.ds_o_bubble_cnt), 64'd0);
        bus.ds_i_change_pc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk($sformatf("sat cnt %0d", i), 64'(bus.ds_o_bubble_cnt), 64'(exp_seq[i]));
        end
        bus.ds_i_change_pc = 1'b0;
        drive_instr(5'd1, 32'd9, 5'd2, 32'd9, 5'd3, 5'd4, 1'b0, 1'b0, 32'h200);
        tick(); settle();
        chk("pre-reset valid", 64'(bus.ds_o_valid), 64'd1);
        bus.ds_i_hold = 1'b1;
        rst = 1'b1;
        tick(); settle();
        chk("reset in hold valid", 64'(bus.ds_o_valid), 64'd0);
        chk("reset in hold cnt",   64'(bus.ds_o_bubble_cnt), 64'd0);
        rst = 1'b0;
        idle_inputs();

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DWIDTH, 32, data width; PC_WIDTH, 32, PC width; IMM_WIDTH, 16, immediate width; AWIDTH, 5, register-address width; CWIDTH, 16, bubble-counter width.
REQ-002 The block SHALL use one clock and a synchronous active-high reset. Ports, clock and reset first:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ds_i_valid  in  1  decode slot holds a real instruction
- ds_i_rs_addr, ds_i_rt_addr, ds_i_rd_addr  in  AWIDTH  source and destination register numbers
- ds_i_data_rs, ds_i_data_rt  in  DWIDTH  register-file read data
- ds_i_imm  in  IMM_WIDTH  raw immediate
- ds_i_funct  in  5  ALU function code, same encoding as the ALU (0 add ... 16 bne)
- ds_i_alu_src  in  1  1 = ALU operand 2 is the immediate
- ds_i_pc  in  PC_WIDTH  instruction PC
- ds_i_reg_write, ds_i_mem_read, ds_i_mem_write  in  1  control bits
- ds_i_hold  in  1  downstream freeze
- ds_i_change_pc  in  1  branch taken in EX, i.e. the ALU change-PC output
- ds_i_exmem_reg_write, ds_i_exmem_rd, ds_i_exmem_value  in  1/AWIDTH/DWIDTH  EX/MEM forward source
- ds_i_memwb_reg_write, ds_i_memwb_rd, ds_i_memwb_value  in  1/AWIDTH/DWIDTH  MEM/WB forward source
- ds_o_valid  out  1  EX slot holds a real instruction
- ds_o_data_rs, ds_o_data_rt  out  DWIDTH  forwarded operands to the ALU
- ds_o_imm, ds_o_funct, ds_o_alu_src, ds_o_pc  out  as inputs  registered copies
- ds_o_rd, ds_o_reg_write, ds_o_mem_read, ds_o_mem_write  out  as inputs  registered copies
- ds_o_stall  out  1  combinational; IF/ID must hold
- ds_o_bubble_cnt  out  CWIDTH  count of inserted bubbles

Function
REQ-003 The pipeline register SHALL capture all ds_i_* payload fields on each rising edge in which a load occurs.
REQ-004 Each edge SHALL take exactly one action, in this priority order:
- rst
- flush (ds_i_change_pc=1)
- hold (ds_i_hold=1)
- stall (ds_o_stall=1)
- load
REQ-005 On flush, the register SHALL load a bubble. A bubble is: valid=0; reg_write, mem_read and mem_write=0; funct=5'd31 (ALU idle); all other fields 0.
REQ-006 On hold, all registers SHALL keep their values, and the bubble counter SHALL NOT change.
REQ-007 ds_o_stall SHALL be 1 when all of the following hold:
- ds_o_valid=1, ds_o_mem_read=1 and ds_o_rd!=0;
- ds_i_valid=1;
- ds_o_rd==ds_i_rs_addr, or ds_o_rd==ds_i_rt_addr while (ds_i_alu_src=0 or ds_i_mem_write=1).
REQ-008 ds_o_stall SHALL be forced to 0 while ds_i_change_pc=1 or ds_i_hold=1.
REQ-009 On stall, the register SHALL load a bubble, so a load-use stall lasts exactly 1 cycle.
REQ-010 On load, the register SHALL capture the decode inputs, and ds_o_valid SHALL equal ds_i_valid.
REQ-011 Forwarding SHALL be combinational from the registered rs/rt addresses. For each operand:
- EX/MEM is used if reg_write=1, rd!=0 and rd matches;
- otherwise MEM/WB is used if reg_write=1, rd!=0 and rd matches;
- otherwise the registered register-file value is used.
REQ-012 Register 0 SHALL never be forwarded; its operand SHALL be the registered value.
REQ-013 When EX/MEM and MEM/WB both match, EX/MEM SHALL win.
REQ-014 ds_o_bubble_cnt SHALL increment by 1 on every flush or stall edge, saturate at 2^CWIDTH-1, and never wrap.
REQ-015 When flush and stall are requested in the same cycle, the flush SHALL take the edge and the counter SHALL increment once.
REQ-016 The latency from the decode inputs to the EX outputs SHALL be 1 cycle. Forwarded operands SHALL change in the same cycle as their forward sources.

Reset
REQ-017 While rst=1 at an edge, the register SHALL load a bubble (REQ-005) and ds_o_bubble_cnt SHALL be set to 0.
REQ-018 Reset SHALL take effect regardless of hold, flush or stall.
REQ-019 Reset SHALL NOT increment ds_o_bubble_cnt.
REQ-020 ds_o_stall SHALL be 0 in the cycle after reset.

Verification
REQ-021 Passthrough: load add, rs=3 (data 5), rt=4 (data 7), no forwarding -> next cycle ds_o_valid=1, funct=0, data_rs=5, data_rt=7, pc copied.
REQ-022 Forward priority: EX holds rs=3; exmem rd=3 value 0x11 and memwb rd=3 value 0x22, both reg_write=1 -> data_rs=0x11. Drop exmem reg_write -> data_rs=0x22.
REQ-023 Load-use: EX holds a load rd=8; decode has rs=8 -> ds_o_stall=1. Next edge loads a bubble with valid=0, and ds_o_bubble_cnt rises 0->1. Following cycle: stall=0, instruction loads.
REQ-024 Flush beats stall and hold: change_pc=1 together with a stall condition and hold=1 -> one bubble, count +1, stall output 0.
REQ-025 Register 0: EX rs=0 with exmem rd=0, reg_write=1, value 0xFF -> data_rs equals the registered value 0.
REQ-026 Saturation, with CWIDTH=2: 5 consecutive flushes -> count sequence 1,2,3,3,3. Then rst=1 mid-hold -> count 0, valid=0.
